cordic_fifo_ctrl: RTL
=====================

CORDIC_FIFO_CTRL -- requirements
Module: cordic_fifo_ctrl

Interface
REQ-001 SHALL have parameter AFULL_TH, default 480, meaning AFULL asserts when COUNT >= AFULL_TH.
REQ-002 SHALL have parameter AEMPTY_TH, default 32, meaning AEMPTY asserts when COUNT <= AEMPTY_TH.
REQ-003 SHALL have port CLK  in  1  single clock for all logic and both RAM ports.
REQ-004 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port WE  in  1  write request; DATA is pushed when WE=1 and FULL=0.
REQ-006 SHALL have port DATA  in  32  write data.
REQ-007 SHALL have port RE  in  1  read request; a pop is accepted when RE=1 and EMPTY=0.
REQ-008 SHALL have port Q  out  32  read data; equals RAM_R_DATA.
REQ-009 SHALL have port DVLD  out  1  Q is valid this cycle.
REQ-010 SHALL have ports FULL, AFULL, EMPTY, AEMPTY  out  1 each  status flags.
REQ-011 SHALL have ports OVERFLOW, UNDERFLOW  out  1 each  one-cycle error pulses.
REQ-012 SHALL have port COUNT  out  10  stored words, 0..512.
REQ-013 SHALL have ports RAM_W_ADDR, RAM_R_ADDR  out  9 each  RAM write and read addresses.
REQ-014 SHALL have ports RAM_W_DATA  out  32, and RAM_W_EN  out  1  RAM write port drive.
REQ-015 SHALL have ports RAM_R_EN, RAM_R_DATA_EN, RAM_R_DATA_SRST_N  out  1 each  RAM read port drive.
REQ-016 SHALL have port RAM_R_DATA  in  32  registered output of the 512x32 two-port RAM.

Function
REQ-017 SHALL accept a write (wr_acc) iff WE=1 and FULL=0, and SHALL then drive RAM_W_EN=1, RAM_W_ADDR=wr_ptr, RAM_W_DATA=DATA combinationally in the same cycle.
REQ-018 SHALL accept a read (rd_acc) iff RE=1 and EMPTY=0, and SHALL then drive RAM_R_EN=1 with RAM_R_ADDR=rd_ptr in the same cycle.
REQ-019 SHALL increment wr_ptr and rd_ptr (9-bit) on each accepted access, wrapping 511 -> 0.
REQ-020 SHALL update COUNT: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
REQ-021 SHALL accept a simultaneous write and read when 0 < COUNT < 512, leaving COUNT unchanged.
REQ-022 SHALL derive FULL (COUNT=512), EMPTY (COUNT=0), AFULL and AEMPTY from the registered COUNT, so flags change the cycle after the access.
REQ-023 SHALL pulse OVERFLOW for one cycle when WE=1 and FULL=1, dropping DATA and leaving the pointers unchanged.
REQ-024 SHALL pulse UNDERFLOW for one cycle when RE=1 and EMPTY=1, issuing no RAM read.
REQ-025 SHALL implement a 2-stage read pipeline, v1 <= rd_acc and v2 <= v1; RAM_R_DATA_EN=v1 and DVLD=v2.
REQ-026 SHALL present data accepted at cycle N on Q with DVLD=1 at cycle N+2; back-to-back reads give one word per cycle.
REQ-027 SHALL hold Q at its last value when DVLD=0, because the RAM output register is enabled only by v1.
REQ-028 SHALL make a word written at cycle N readable by a read accepted at cycle N+1 or later.
REQ-029 SHALL never read and write the same RAM address in one cycle; the REQ-017/018 gating guarantees this.

Reset
REQ-030 SHALL, while RESET=1, asynchronously clear wr_ptr, rd_ptr, COUNT, v1, v2, OVERFLOW and UNDERFLOW, giving EMPTY=1, AEMPTY=1, FULL=0, AFULL=0, DVLD=0.
REQ-031 SHALL drive RAM_R_DATA_SRST_N=0 while RESET=1 and for one cycle after deassertion (registered), clearing the RAM output register so Q=0.
REQ-032 SHALL discard any in-flight reads when RESET is asserted mid-operation, with no DVLD pulse afterwards.

Verification
REQ-033 SHALL be verified for this case: write 0x0000_0001..0x0000_0003, then RE for 3 cycles -> Q=1,2,3 on consecutive cycles, each 2 cycles after its read, DVLD=1 for exactly 3 cycles, EMPTY=1 after.
REQ-034 SHALL be verified for this case: 512 writes -> FULL=1 and COUNT=512; a 513th WE -> OVERFLOW for 1 cycle, COUNT stays 512; drain 512 -> data in order, EMPTY=1.
REQ-035 SHALL be verified for this case: wrap-around, 300 writes / 300 reads repeated twice -> pointers pass 511 -> 0 and no data corruption.
REQ-036 SHALL be verified for this case: simultaneous WE and RE at COUNT=5 for 10 cycles -> COUNT stays 5 and output order is preserved.
REQ-037 SHALL be verified for this case: RE at EMPTY -> UNDERFLOW pulse, RAM_R_EN=0, DVLD stays 0; AFULL asserts at COUNT=480 and AEMPTY deasserts at COUNT=33.
REQ-038 SHALL be verified for this case: RESET asserted 1 cycle after a read was accepted -> no DVLD, COUNT=0, RAM_R_DATA_SRST_N low through the first cycle after release.

Source files
------------

// File: rtl/cordic_fifo_ctrl.sv
// cordic_fifo_ctrl: 512x32 FIFO controller driving an external two-port RAM with a registered read port
module cordic_fifo_ctrl #(
  parameter int AFULL_TH  = 480,
  parameter int AEMPTY_TH = 32
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        WE,
  input  logic [31:0] DATA,
  input  logic        RE,
  output logic [31:0] Q,
  output logic        DVLD,
  output logic        FULL,
  output logic        AFULL,
  output logic        EMPTY,
  output logic        AEMPTY,
  output logic        OVERFLOW,
  output logic        UNDERFLOW,
  output logic [9:0]  COUNT,
  output logic [8:0]  RAM_W_ADDR,
  output logic [8:0]  RAM_R_ADDR,
  output logic [31:0] RAM_W_DATA,
  output logic        RAM_W_EN,
  output logic        RAM_R_EN,
  output logic        RAM_R_DATA_EN,
  output logic        RAM_R_DATA_SRST_N,
  input  logic [31:0] RAM_R_DATA
);
  localparam logic [9:0] AF = 10'(AFULL_TH);
  localparam logic [9:0] AE = 10'(AEMPTY_TH);
  logic [8:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [9:0] count_q, count_d;
  logic       v1_q, v2_q, ovf_q, unf_q, srst_n_q;
  logic       wr_acc, rd_acc;
  assign FULL   = count_q == 10'd512;
  assign EMPTY  = count_q == 10'd0;
  assign AFULL  = count_q >= AF;
  assign AEMPTY = count_q <= AE;
  assign COUNT  = count_q;
  assign wr_acc = WE & ~FULL;
  assign rd_acc = RE & ~EMPTY;
  assign RAM_W_EN          = wr_acc;
  assign RAM_W_ADDR        = wr_ptr_q;
  assign RAM_W_DATA        = DATA;
  assign RAM_R_EN          = rd_acc;
  assign RAM_R_ADDR        = rd_ptr_q;
  assign RAM_R_DATA_EN     = v1_q;
  assign RAM_R_DATA_SRST_N = srst_n_q;
  assign DVLD      = v2_q;
  assign Q         = RAM_R_DATA;
  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = unf_q;
  // next pointers and occupancy; a simultaneous write and read leaves the count alone
  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + 9'd1 : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + 9'd1 : rd_ptr_q;
    count_d  = (wr_acc && !rd_acc) ? count_q + 10'd1 :
               (rd_acc && !wr_acc) ? count_q - 10'd1 : count_q;
  end
  // state registers; the RAM output register is held in reset one cycle past release
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      srst_n_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      v1_q     <= rd_acc;
      v2_q     <= v1_q;
      ovf_q    <= WE & FULL;
      unf_q    <= RE & EMPTY;
      srst_n_q <= 1'b1;
    end
  end
endmodule
